// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter in front of a single-ported
// SRAM with a registered (1-cycle latency) read path.
// Each access: IDLE -> ACCESS (enables driven) -> IDLE for writes,
// IDLE -> ACCESS -> RESP (read data captured) -> IDLE for reads.
// All outputs are registered.

module sram_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              sram_clk,
  input  logic              sram_ares,
  // requester port 0
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  // requester port 1
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  // SRAM side
  output logic              mem_wr_enable,
  output logic              mem_rd_enable,
  output logic [ADDR_W-1:0] mem_index,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  // status
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  logic   ptr;      // favoured port on simultaneous requests
  logic   sel;      // port owning the access in flight
  logic   cur_we;   // latched direction of the access in flight

  logic              any_req;
  logic              pick;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;

  // Round-robin selection among the ports requesting right now
  always_comb begin
    any_req = p0_req | p1_req;
    if (p0_req && p1_req) begin
      pick = ptr;
    end else begin
      pick = p1_req;
    end
    pick_we    = pick ? p1_we    : p0_we;
    pick_addr  = pick ? p1_addr  : p0_addr;
    pick_wdata = pick ? p1_wdata : p0_wdata;
  end

  // Arbitration FSM with registered SRAM controls and requester responses
  always_ff @(posedge sram_clk) begin
    if (sram_ares) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      sel           <= 1'b0;
      cur_we        <= 1'b0;
      p0_gnt        <= 1'b0;
      p1_gnt        <= 1'b0;
      p0_rvalid     <= 1'b0;
      p1_rvalid     <= 1'b0;
      p0_rdata      <= '0;
      p1_rdata      <= '0;
      mem_wr_enable <= 1'b0;
      mem_rd_enable <= 1'b0;
      mem_index     <= '0;
      mem_data_in   <= '0;
      busy          <= 1'b0;
    end else begin
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            sel           <= pick;
            ptr           <= ~pick;
            cur_we        <= pick_we;
            mem_wr_enable <= pick_we;
            mem_rd_enable <= ~pick_we;
            mem_index     <= pick_addr;
            mem_data_in   <= pick_wdata;
            p0_gnt        <= ~pick;
            p1_gnt        <= pick;
            busy          <= 1'b1;
            state         <= ACCESS;
          end else begin
            mem_wr_enable <= 1'b0;
            mem_rd_enable <= 1'b0;
            busy          <= 1'b0;
          end
        end
        ACCESS: begin
          mem_wr_enable <= 1'b0;
          mem_rd_enable <= 1'b0;
          if (cur_we) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            busy  <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          if (sel) begin
            p1_rdata  <= mem_data_out;
            p1_rvalid <= 1'b1;
          end else begin
            p0_rdata  <= mem_data_out;
            p0_rvalid <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_wr_enable <= 1'b0;
          mem_rd_enable <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a driver issues request rounds and
// pushes predicted grants (round-robin order, memory contents) into a queue;
// a negedge monitor pops and compares whenever the DUT grants or responds.
`timescale 1ns/1ps

module tb_sram_arbiter;

  localparam int AW = 7;
  localparam int DW = 8;

  logic          sram_clk = 1'b0;
  logic          sram_ares = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_wr_enable, mem_rd_enable, busy;
  logic [AW-1:0] mem_index;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out = '0;

  always #5 sram_clk = ~sram_clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .sram_clk(sram_clk), .sram_ares(sram_ares),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_wr_enable(mem_wr_enable), .mem_rd_enable(mem_rd_enable),
    .mem_index(mem_index), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  // External SRAM: registered read, 1-cycle latency
  logic [DW-1:0] sram_mem [128];
  always @(posedge sram_clk) begin
    if (mem_wr_enable) sram_mem[mem_index] <= mem_data_in;
    if (mem_rd_enable) mem_data_out <= sram_mem[mem_index];
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DW-1:0] ref_mem [128];
  int            ptr;
  exp_t          exp_q [$];
  rd_t           rd_q [$];
  logic [DW-1:0] exp_rdata [2];
  logic [AW-1:0] last_idx;
  logic [DW-1:0] last_din;
  int            busy_left;
  bit            mon_en = 1'b0;
  int            mon_cyc = 0;
  exp_t          mon_e;
  rd_t           mon_r;

  txn_t lst0 [$];
  txn_t lst1 [$];
  txn_t alt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.data = d;
    return t;
  endfunction

  function automatic txn_t rand_txn(input bit force_read);
    txn_t t;
    t.we   = force_read ? 1'b0 : 1'($urandom_range(0, 1));
    t.addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 127)) : AW'($urandom_range(0, 7));
    t.data = DW'($urandom);
    return t;
  endfunction

  // Model: a granted transaction acts on memory in grant order; pointer flips away from winner
  task automatic model_push(input int p, input txn_t t);
    exp_t e;
    e.port  = p;
    e.we    = t.we;
    e.addr  = t.addr;
    e.wdata = t.data;
    e.rdata = '0;
    if (t.we) ref_mem[t.addr] = t.data;
    else      e.rdata = ref_mem[t.addr];
    exp_q.push_back(e);
    ptr = 1 - p;
  endtask

  task automatic drive(input int p, input txn_t t);
    if (p == 0) begin
      p0_we = t.we; p0_addr = t.addr; p0_wdata = t.data; p0_req = 1'b1;
    end else begin
      p1_we = t.we; p1_addr = t.addr; p1_wdata = t.data; p1_req = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sram_clk); #1;
    end
  endtask

  task automatic do_reset(input int n);
    sram_ares = 1'b1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    idle(n);
    exp_q.delete();
    rd_q.delete();
    busy_left = 0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    last_idx = '0;
    last_din = '0;
    ptr = 0;
    sram_ares = 1'b0;
    mon_en = 1'b1;
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_p1_gnt", p1_gnt, 0);
    chk("rst_p0_rvalid", p0_rvalid, 0);
    chk("rst_p1_rvalid", p1_rvalid, 0);
    chk("rst_wr_en", mem_wr_enable, 0);
    chk("rst_rd_en", mem_rd_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_index", mem_index, 0);
    chk("rst_data_in", mem_data_in, 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    chk("rst_p1_rdata", p1_rdata, 0);
  endtask

  // Issue lst0/lst1; each port re-requests immediately after its grant while it
  // has items left. Delayed mode: p1 appears during p0's read RESP with alt,
  // then switches to lst1[0] before its granting edge.
  task automatic run_round(input bit delayed);
    int n0, n1, i0, i1, k0, k1, stage, wait_cnt, since, prev_we;
    bit have_prev;
    n0 = lst0.size();
    n1 = lst1.size();
    i0 = 0; i1 = 0;
    if (delayed) begin
      model_push(0, lst0[0]);
      model_push(1, lst1[0]);
    end else begin
      while (i0 < n0 || i1 < n1) begin
        if (i0 < n0 && (i1 >= n1 || ptr == 0)) begin
          model_push(0, lst0[i0]); i0++;
        end else begin
          model_push(1, lst1[i1]); i1++;
        end
      end
    end
    k0 = 0; k1 = 0; stage = 0; wait_cnt = 0; since = 0; prev_we = 0; have_prev = 1'b0;
    if (n0 > 0) drive(0, lst0[0]);
    if (n1 > 0 && !delayed) drive(1, lst1[0]);
    while ((k0 < n0 || k1 < n1) && wait_cnt < 60) begin
      @(posedge sram_clk); #1;
      since++;
      wait_cnt++;
      if (stage == 2) begin
        if (k1 == 0) drive(1, lst1[0]);
        stage = 3;
      end
      if (stage == 1) begin
        drive(1, alt);
        stage = 2;
      end
      if (p0_gnt) begin
        if (have_prev) chk("gnt_spacing_p0", since, prev_we ? 2 : 3);
        have_prev = 1'b1; since = 0; wait_cnt = 0;
        prev_we = int'(lst0[k0].we);
        k0++;
        if (k0 < n0) drive(0, lst0[k0]);
        else p0_req = 1'b0;
        if (delayed) stage = 1;
      end
      if (p1_gnt) begin
        if (have_prev) chk("gnt_spacing_p1", since, prev_we ? 2 : 3);
        have_prev = 1'b1; since = 0; wait_cnt = 0;
        prev_we = (k1 < n1) ? int'(lst1[k1].we) : 0;
        k1++;
        if (k1 < n1) drive(1, lst1[k1]);
        else p1_req = 1'b0;
      end
    end
    chk("round_grants", k0 + k1, n0 + n1);
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  // Monitor: compares every cycle against the scoreboard
  always @(negedge sram_clk) begin
    if (mon_en) begin
      mon_cyc++;
      chk("gnt_exclusive", p0_gnt & p1_gnt, 0);
      chk("rvalid_exclusive", p0_rvalid & p1_rvalid, 0);
      chk("enables_exclusive", mem_wr_enable & mem_rd_enable, 0);
      if (p0_gnt || p1_gnt) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_gnt", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("gnt_port", p1_gnt ? 1 : 0, mon_e.port);
          chk("access_wr_en", mem_wr_enable, mon_e.we);
          chk("access_rd_en", mem_rd_enable, !mon_e.we);
          chk("access_index", mem_index, mon_e.addr);
          chk("access_data_in", mem_data_in, mon_e.wdata);
          last_idx = mon_e.addr;
          last_din = mon_e.wdata;
          busy_left = mon_e.we ? 1 : 2;
          if (!mon_e.we) begin
            mon_r.port = mon_e.port;
            mon_r.data = mon_e.rdata;
            mon_r.due  = mon_cyc + 2;
            rd_q.push_back(mon_r);
          end
        end
      end else begin
        chk("idle_wr_en", mem_wr_enable, 0);
        chk("idle_rd_en", mem_rd_enable, 0);
        chk("hold_index", mem_index, last_idx);
        chk("hold_data_in", mem_data_in, last_din);
      end
      chk("busy", busy, busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (p0_rvalid || p1_rvalid) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_rvalid", 1, 0);
        end else begin
          mon_r = rd_q.pop_front();
          chk("rvalid_port", p1_rvalid ? 1 : 0, mon_r.port);
          chk("rvalid_latency", mon_cyc, mon_r.due);
          chk("rvalid_rdata", mon_r.port == 1 ? p1_rdata : p0_rdata, mon_r.data);
          exp_rdata[mon_r.port] = mon_r.data;
        end
      end else if (rd_q.size() > 0 && rd_q[0].due <= mon_cyc) begin
        chk("rvalid_missing", 0, 1);
        void'(rd_q.pop_front());
      end
      chk("p0_rdata_hold", p0_rdata, exp_rdata[0]);
      chk("p1_rdata_hold", p1_rdata, exp_rdata[1]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    @(posedge sram_clk); #1;
    do_reset(3);

    // both reads requested together right after reset: p0 first, p1 three cycles later
    lst0.delete(); lst1.delete();
    lst0.push_back(mk(1'b0, 7'h21, 8'h00));
    lst1.push_back(mk(1'b0, 7'h22, 8'h00));
    run_round(1'b0);
    // pointer is back on port 0: p0 wins again
    lst0.delete(); lst1.delete();
    lst0.push_back(mk(1'b1, 7'h30, 8'h3C));
    lst1.push_back(mk(1'b1, 7'h31, 8'hC3));
    run_round(1'b0);
    idle(2);

    // port 0 write 0x05 <= 0xA5 then read it back
    lst0.delete(); lst1.delete();
    lst0.push_back(mk(1'b1, 7'h05, 8'hA5));
    lst0.push_back(mk(1'b0, 7'h05, 8'h00));
    run_round(1'b0);
    idle(3);

    // top-of-range index on port 1; p0_rdata must stay put
    lst0.delete(); lst1.delete();
    lst1.push_back(mk(1'b1, 7'h7F, 8'h7F));
    lst1.push_back(mk(1'b0, 7'h7F, 8'h00));
    run_round(1'b0);
    idle(2);

    // p1 arrives during p0 read response; its late address change is what counts
    lst0.delete(); lst1.delete();
    lst0.push_back(mk(1'b0, 7'h05, 8'h00));
    alt = mk(1'b0, 7'h30, 8'h00);
    lst1.push_back(mk(1'b0, 7'h31, 8'h00));
    run_round(1'b1);
    idle(3);

    // both ports stream writes back to back: strict alternation
    lst0.delete(); lst1.delete();
    for (int i = 0; i < 4; i++) begin
      lst0.push_back(mk(1'b1, AW'(8 + i), DW'($urandom)));
      lst1.push_back(mk(1'b1, AW'(12 + i), DW'($urandom)));
    end
    run_round(1'b0);
    idle(3);

    // reset during RESP of a read of 0x10: no rvalid afterwards
    begin
      int w;
      txn_t t;
      t = mk(1'b0, 7'h10, 8'h00);
      model_push(0, t);
      drive(0, t);
      w = 0;
      while (!p0_gnt && w < 20) begin
        @(posedge sram_clk); #1;
        w++;
      end
      chk("abort_read_gnt", p0_gnt, 1);
      p0_req = 1'b0;
      @(posedge sram_clk); #1;
      chk("abort_in_resp_busy", busy, 1);
      do_reset(1);
      idle(4);
    end

    // randomized rounds
    for (int r = 0; r < 150; r++) begin
      int n0, n1;
      lst0.delete(); lst1.delete();
      if ($urandom_range(0, 7) == 0) begin
        lst0.push_back(rand_txn(1'b1));
        alt = rand_txn(1'b0);
        lst1.push_back(rand_txn(1'b0));
        run_round(1'b1);
      end else begin
        n0 = $urandom_range(0, 3);
        n1 = $urandom_range(0, 3);
        if (n0 == 0 && n1 == 0) n0 = 1;
        for (int i = 0; i < n0; i++) lst0.push_back(rand_txn(1'b0));
        for (int i = 0; i < n1; i++) lst1.push_back(rand_txn(1'b0));
        run_round(1'b0);
      end
      idle($urandom_range(0, 2));
    end

    idle(8);
    chk("gnt_queue_drained", exp_q.size(), 0);
    chk("rvalid_queue_drained", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, meaning the SRAM index width (128 entries).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the SRAM data width (one byte).
REQ-003 The block SHALL use one clock and a synchronous active-high reset; all ports are listed below.
- sram_clk  in  1  clock; all logic on rising edge
- sram_ares  in  1  synchronous active-high reset
- p0_req / p1_req  in  1  access request, held until grant
- p0_we / p1_we  in  1  1=write, 0=read; valid with req
- p0_addr / p1_addr  in  ADDR_W  SRAM index; valid with req
- p0_wdata / p1_wdata  in  DATA_W  write data; valid with req
- p0_gnt / p1_gnt  out  1  one-cycle pulse: request accepted
- p0_rvalid / p1_rvalid  out  1  one-cycle pulse: read data valid
- p0_rdata / p1_rdata  out  DATA_W  read data, held until next read of that port
- mem_wr_enable  out  1  to SRAM wr_enable
- mem_rd_enable  out  1  to SRAM rd_enable
- mem_index  out  ADDR_W  to SRAM ram_index
- mem_data_in  out  DATA_W  to SRAM sram_data_in
- mem_data_out  in  DATA_W  from SRAM sram_data_out (registered, 1-cycle read latency)
- busy  out  1  high whenever FSM not in IDLE

Function
REQ-004 The block SHALL implement FSM states IDLE, ACCESS, RESP; all outputs registered.
REQ-005 In IDLE with no request, the block SHALL hold all mem_* enables low and stay in IDLE.
REQ-006 In IDLE with >=1 request at edge E0, the block SHALL select one port, latch its we/addr/wdata onto mem_*, pulse that port's gnt for the cycle after E0, and enter ACCESS.
REQ-007 Exactly one of mem_wr_enable/mem_rd_enable SHALL be high in ACCESS (per latched we); both SHALL be low in every other state.
REQ-008 From ACCESS at E1, a write SHALL return to IDLE; a read SHALL enter RESP with enables low.
REQ-009 In RESP at E2, the block SHALL capture mem_data_out into the granted port's rdata, pulse its rvalid for the cycle after E2, and return to IDLE.
REQ-010 Latency: write occupies 2 cycles (gnt to next possible gnt); read gives rvalid 2 cycles after gnt and occupies 3 cycles.
REQ-011 Arbitration SHALL be round-robin: a priority pointer names the favoured port; on simultaneous requests the favoured port wins; after any grant the pointer SHALL point to the other port.
REQ-012 A single requesting port SHALL be granted regardless of the pointer; the pointer still updates per REQ-011.
REQ-013 Requests arriving while busy SHALL be ignored until IDLE; requester inputs are sampled only at the granting edge.
REQ-014 A requester that keeps req high after gnt SHALL be treated as a new request at the next IDLE (back-to-back allowed, subject to REQ-011).
REQ-015 gnt and rvalid SHALL never be asserted for both ports in the same cycle.
REQ-016 mem_index and mem_data_in SHALL hold their last values outside ACCESS.
REQ-017 rdata of the non-responding port SHALL be unchanged.

Reset
REQ-018 On sram_ares high at an edge, the block SHALL enter IDLE, set pointer to port 0, and drive all gnt, rvalid, mem_wr_enable, mem_rd_enable, busy to 0 and all rdata, mem_index, mem_data_in to 0.
REQ-019 Reset in ACCESS or RESP SHALL abort the operation; no rvalid SHALL follow reset.

Verification
REQ-020 Port 0 write addr 0x05 data 0xA5, then port 0 read 0x05 -> mem_wr_enable one cycle with index 0x05/data 0xA5; p0_rvalid 2 cycles after read gnt with p0_rdata=0xA5.
REQ-021 After reset, p0_req and p1_req asserted same cycle (both reads) -> p0_gnt first, p1_gnt 3 cycles later; pointer then favours port 0.
REQ-022 Both ports hold req continuously with writes -> grants alternate p0,p1,p0,p1 every 2 cycles; never both enables high.
REQ-023 p1 requests while p0 read is in RESP -> p1_gnt only after IDLE; p1_addr changes before grant are honoured at granting edge.
REQ-024 sram_ares asserted during RESP of read of 0x10 -> no rvalid, all outputs 0 next cycle, busy=0.
REQ-025 Write 0x7F to index 0x7F (wrap boundary) then read -> p1_rdata=0x7F; p0_rdata unchanged.
